// File: rtl/mic1_run_sequencer_if.sv
// Button, breakpoint and status bundle between the board top level and mic1_run_sequencer.
interface mic1_run_sequencer_if #(
  parameter int MPC_W = 9,
  parameter int CNT_W = 32
);
  logic             btn_run;
  logic             btn_step;
  logic             btn_stop;
  logic             bp_valid;
  logic [MPC_W-1:0] bp_addr;
  logic [MPC_W-1:0] mpc;
  logic             mic1_run;
  logic             led_run;
  logic             led_idle;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output btn_run, btn_step, btn_stop, bp_valid, bp_addr, mpc,
    input  mic1_run, led_run, led_idle, halted, cycle_count
  );

  modport slave (
    input  btn_run, btn_step, btn_stop, bp_valid, bp_addr, mpc,
    output mic1_run, led_run, led_idle, halted, cycle_count
  );
endinterface

// File: rtl/mic1_run_sequencer.sv
// Run-control sequencer for mic1_soc: run/step/stop buttons to mic1_run, with run limit and cycle count.
// Define MIC1_BREAKPOINT_EN to halt RUN when mpc matches an armed breakpoint address.
module mic1_run_sequencer #(
  parameter int STEP_CYCLES = 1,
  parameter int RUN_LIMIT   = 0,
  parameter int CNT_W       = 32,
  parameter int MPC_W       = 9
) (
  input logic                 clk,
  input logic                 resetn,
  mic1_run_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

  localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'((RUN_LIMIT > 0) ? RUN_LIMIT - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] run_cnt;
  logic [SC_W-1:0]  step_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic             step_prev;
  logic             step_edge;
  logic             run_active;
  logic             bp_hit;
  logic [MPC_W-1:0] mpc_val;

  assign mpc_val    = bus.mpc;
  assign step_edge  = bus.btn_step & ~step_prev;
  assign run_active = (state == RUN) || (state == STEP);

`ifdef MIC1_BREAKPOINT_EN
  // The first RUN cycle ignores a match so RUN can resume from the breakpoint address.
  logic run_first;

  always_ff @(posedge clk) begin
    if (!resetn) run_first <= 1'b0;
    else         run_first <= (state_nxt == RUN) && (state != RUN);
  end

  assign bp_hit = !run_first && bus.bp_valid && (mpc_val == bus.bp_addr);
`else
  logic [2*MPC_W:0] unused_bp;
  assign unused_bp = {bus.bp_valid, bus.bp_addr, mpc_val};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.btn_stop)     state_nxt = IDLE;
        else if (bus.btn_run) state_nxt = RUN;
        else if (step_edge)   state_nxt = STEP;
      end
      RUN: begin
        if (bus.btn_stop)                             state_nxt = IDLE;
        else if ((RUN_LIMIT != 0) && (run_cnt == RUN_LAST)) state_nxt = HALT;
        else if (bp_hit)                              state_nxt = HALT;
      end
      STEP: begin
        if (bus.btn_stop || (step_cnt == '0)) state_nxt = IDLE;
      end
      HALT: begin
        if (bus.btn_stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // run_cnt is held at zero outside RUN, so it is already cleared on every RUN entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      step_prev <= 1'b1;
      run_cnt   <= '0;
      step_cnt  <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      step_prev <= bus.btn_step;
      if (state == RUN) run_cnt <= run_cnt + 1'b1;
      else              run_cnt <= '0;
      if (state == IDLE)                         step_cnt <= STEP_LAST;
      else if ((state == STEP) && (step_cnt != '0)) step_cnt <= step_cnt - 1'b1;
      if (run_active && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign bus.mic1_run    = run_active;
  assign bus.led_run     = run_active;
  assign bus.led_idle    = !run_active;
  assign bus.halted      = (state == HALT);
  assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_mic1_run_sequencer.sv
// Directed bench: dut_a (STEP_CYCLES=3, RUN_LIMIT=10) and dut_b (CNT_W=4, unlimited run).
module tb_mic1_run_sequencer;

  logic clk;
  logic resetn;
  int   num_compared;
  int   num_mismatched;
  int   high_cnt;

  mic1_run_sequencer_if #(.MPC_W(9), .CNT_W(32)) if_a ();
  mic1_run_sequencer_if #(.MPC_W(9), .CNT_W(4))  if_b ();

  mic1_run_sequencer #(.STEP_CYCLES(3), .RUN_LIMIT(10), .CNT_W(32), .MPC_W(9)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_a)
  );

  mic1_run_sequencer #(.STEP_CYCLES(1), .RUN_LIMIT(0), .CNT_W(4), .MPC_W(9)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic stop);
    if_a.btn_run  = run;
    if_a.btn_step = step;
    if_a.btn_stop = stop;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    resetn         = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    if_a.bp_valid = 1'b0; if_a.bp_addr = 9'h000; if_a.mpc = 9'h000;
    if_b.btn_run = 1'b0; if_b.btn_step = 1'b0; if_b.btn_stop = 1'b0;
    if_b.bp_valid = 1'b0; if_b.bp_addr = 9'h000; if_b.mpc = 9'h000;

    // Reset with step held, then release: no step fires.
    repeat (3) tick();
    checkOutput("rst_run",      32'(if_a.mic1_run), 32'd0);
    checkOutput("rst_led_run",  32'(if_a.led_run),  32'd0);
    checkOutput("rst_led_idle", 32'(if_a.led_idle), 32'd1);
    checkOutput("rst_halted",   32'(if_a.halted),   32'd0);
    resetn = 1'b1;
    repeat (3) tick();
    checkOutput("held_step_run", 32'(if_a.mic1_run),  32'd0);
    checkOutput("held_step_cnt", if_a.cycle_count,    32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // One step request gives three run cycles; a second edge inside the step is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_a.mic1_run) high_cnt++;
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 1) applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("step_cycles",   32'(high_cnt),      32'd3);
    checkOutput("step_end_run",  32'(if_a.mic1_run), 32'd0);
    checkOutput("step_count",    if_a.cycle_count,   32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // Run pulse hits the 10-cycle limit and halts.
    applyStimulus(1'b1, 1'b0, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (if_a.mic1_run) high_cnt++;
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("limit_cycles",   32'(high_cnt),      32'd10);
    checkOutput("limit_halted",   32'(if_a.halted),   32'd1);
    checkOutput("limit_run",      32'(if_a.mic1_run), 32'd0);
    checkOutput("limit_led_idle", 32'(if_a.led_idle), 32'd1);
    checkOutput("limit_count",    if_a.cycle_count,   32'd13);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("halt_ignores_run",  32'(if_a.halted),   32'd1);
    checkOutput("halt_run_low",      32'(if_a.mic1_run), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("halt_stop_halted",  32'(if_a.halted),   32'd0);
    checkOutput("halt_stop_run",     32'(if_a.mic1_run), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // Stop beats run in IDLE; stop mid-run drops mic1_run next cycle; held run waits for stop release.
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("run_stop_idle", 32'(if_a.mic1_run), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("run_after_release", 32'(if_a.mic1_run), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("stop_mid_run", 32'(if_a.mic1_run), 32'd0);
    tick();
    checkOutput("run_held_stop", 32'(if_a.mic1_run), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stop_count", if_a.cycle_count, 32'd15);

    // Breakpoint at 0x05 presented on the fourth run cycle.
    if_a.bp_valid = 1'b1;
    if_a.bp_addr  = 9'h005;
    if_a.mpc      = 9'h000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    high_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
      if (if_a.mic1_run) high_cnt++;
      if (if_a.mic1_run && high_cnt == 4) if_a.mpc = 9'h005;
      else                                if_a.mpc = 9'h000;
    end
`ifdef MIC1_BREAKPOINT_EN
    checkOutput("bp_cycles", 32'(high_cnt),    32'd4);
    checkOutput("bp_halted", 32'(if_a.halted), 32'd1);
`else
    checkOutput("bp_ignored_cycles", 32'(high_cnt),    32'd8);
    checkOutput("bp_ignored_halted", 32'(if_a.halted), 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    // Resume with the match present on the first run cycle: no halt.
    if_a.mpc = 9'h005;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_resume_run",    32'(if_a.mic1_run), 32'd1);
    checkOutput("bp_resume_halted", 32'(if_a.halted),   32'd0);
    if_a.mpc = 9'h000;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    if_a.bp_valid = 1'b0;
    tick();

    // dut_b: single-cycle step, then saturation of the 4-bit counter.
    if_b.btn_step = 1'b1;
    high_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if_b.mic1_run) high_cnt++;
    end
    if_b.btn_step = 1'b0;
    checkOutput("b_step_cycles", 32'(high_cnt),         32'd1);
    checkOutput("b_step_count",  32'(if_b.cycle_count), 32'd1);
    if_b.btn_run = 1'b1;
    repeat (10) tick();
    checkOutput("b_count_mid", 32'(if_b.cycle_count), 32'd10);
    repeat (10) tick();
    checkOutput("b_count_sat", 32'(if_b.cycle_count), 32'd15);
    checkOutput("b_still_run", 32'(if_b.mic1_run),    32'd1);
    if_b.btn_run  = 1'b0;
    if_b.btn_stop = 1'b1;
    tick();
    if_b.btn_stop = 1'b0;
    tick();
    checkOutput("b_stop_run",  32'(if_b.mic1_run),    32'd0);
    checkOutput("b_count_hold", 32'(if_b.cycle_count), 32'd15);

    // Reset in the middle of a step, step held through reset.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("midstep_run", 32'(if_a.mic1_run), 32'd1);
    resetn = 1'b0;
    tick();
    checkOutput("midstep_rst_run", 32'(if_a.mic1_run), 32'd0);
    checkOutput("midstep_rst_cnt", if_a.cycle_count,   32'd0);
    resetn = 1'b1;
    repeat (3) tick();
    checkOutput("midstep_no_fire", 32'(if_a.mic1_run), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
